// File: rtl/s_mem_arbiter_pkg.sv
// s_mem_arb_pkg: shared types and constants for the working-RAM arbiter.
//   arb_state_t  : arbiter FSM states (idle / a requester owns the RAM)
//   REQ_*        : requester index assignment used by the key-search top level
//   DEF_*        : default widths for the arbiter and its bus interface
//   idx_width()  : width of a requester index, never less than one bit
package s_mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

  localparam int REQ_POP  = 0;
  localparam int REQ_SHUF = 1;
  localparam int REQ_DEC  = 2;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;

  // A single requester still needs a 1-bit owner/pointer field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s_mem_arbiter_if.sv
// s_mem_arbiter_if: requester-side bus of the working-RAM arbiter.
//   req/lock/wren : per-requester access request, burst lock, write qualifier
//   addr/wdata    : flattened per-requester address and write data
//                   (requester i at [i*W +: W])
//   gnt/rvalid    : registered one-hot grant and read-data-valid pulses
//   rdata         : RAM read data broadcast to every requester
//   owner/busy    : index of the current owner, any-grant flag
// Modports: master = requester side, slave = arbiter side.
interface s_mem_arbiter_if
  import s_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        wren;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [IDX_W-1:0]          owner;
  logic                      busy;

  modport master (
    output req, lock, wren, addr, wdata,
    input  gnt, rvalid, rdata, owner, busy
  );

  modport slave (
    input  req, lock, wren, addr, wdata,
    output gnt, rvalid, rdata, owner, busy
  );

endinterface

// File: rtl/s_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  : request vector
//   ptr   in  : highest-priority index for this pick
//   valid out : some request bit is set
//   idx   out : first set request at index >= ptr, wrapping modulo NUM_REQ
module rr_pick
  import s_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down to ptr itself so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin arbiter and port mux in front of the single-port
// working RAM (s_memory).
//   clk          in  : system clock (CLOCK_50 at the top level)
//   reset_n      in  : asynchronous active-low reset
//   bus          if  : requester bus (slave modport), see s_mem_arbiter_if
//   mem_address  out : RAM address (owner's addr, held while idle)
//   mem_data     out : RAM write data (owner's wdata, held while idle)
//   mem_wren     out : RAM write enable, owner write accesses only
//   mem_q        in  : RAM read data, valid one cycle after the address edge
module s_mem_arbiter
  import s_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  s_mem_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t         state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] rvalid_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [ADDR_W-1:0]  addr_hold_reg;
  logic [DATA_W-1:0]  data_hold_reg;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after;
  logic               pick_valid;
  logic               owned;
  logic               owner_req;
  logic               owner_lock;
  logic               owner_wren;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]    = bus.addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]   = bus.wdata[gi*DATA_W +: DATA_W];
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  assign owned      = (state_reg == ARB_OWNED);
  assign owner_req  = bus.req[owner_reg];
  assign owner_lock = bus.lock[owner_reg];
  assign owner_wren = bus.wren[owner_reg];

  // Pointer value that takes effect on a release edge; it also steers the
  // same-edge re-arbitration so the handoff costs no idle cycle.
  assign ptr_after = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
  assign pick_ptr  = owned ? ptr_after : ptr_reg;
  assign pick_req  = bus.req & ~gnt_reg;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the owner's lane reaches the RAM; while idle the last driven
  // address/data are replayed from the hold registers.
  assign mem_address = owned ? addr_arr[owner_reg]  : addr_hold_reg;
  assign mem_data    = owned ? wdata_arr[owner_reg] : data_hold_reg;
  assign mem_wren    = owned & gnt_reg[owner_reg] & owner_req & owner_wren;

  assign bus.gnt    = gnt_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = mem_q;
  assign bus.owner  = owner_reg;
  assign bus.busy   = |gnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ARB_IDLE;
      gnt_reg       <= '0;
      rvalid_reg    <= '0;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else begin
      rvalid_reg <= '0;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_reg   <= pick_onehot;
            owner_reg <= pick_idx;
            state_reg <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          addr_hold_reg <= addr_arr[owner_reg];
          data_hold_reg <= wdata_arr[owner_reg];
          if (owner_req) begin
            rvalid_reg[owner_reg] <= ~owner_wren;
          end else if (!owner_lock) begin
            ptr_reg <= ptr_after;
            if (pick_valid) begin
              gnt_reg   <= pick_onehot;
              owner_reg <= pick_idx;
            end else begin
              gnt_reg   <= '0;
              state_reg <= ARB_IDLE;
            end
          end
          // lock held with req low: burst gap, grant stays put
        end
        default: begin
          gnt_reg   <= '0;
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: self-checking bench for s_mem_arbiter with a synchronous
// RAM model and a transaction-level reference model of the arbitration rules.
module tb_s_mem_arbiter;
  import s_mem_arb_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_t, lock_t, wren_t;
  logic [7:0]   addr_t  [N];
  logic [7:0]   wdata_t [N];
  logic [7:0]   mem_address, mem_data, mem_q;
  logic         mem_wren;

  int errors = 0;
  int checks = 0;

  s_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) bus ();

  assign bus.req   = req_t;
  assign bus.lock  = lock_t;
  assign bus.wren  = wren_t;
  assign bus.addr  = {addr_t[2], addr_t[1], addr_t[0]};
  assign bus.wdata = {wdata_t[2], wdata_t[1], wdata_t[0]};

  s_mem_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  // ---------------- RAM model (s_memory stand-in) ----------------
  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  logic [7:0] ram [256];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_wren) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
    end
  end

  // ---------------- reference model ----------------
  int         m_owner;   // -1 when nobody holds the grant
  int         m_ptr;
  int         m_last;    // last owner index (what `owner` shows)
  logic [7:0] m_ram [256];
  logic [7:0] m_hold_addr, m_hold_data;
  logic [N-1:0] exp_rvalid;
  logic [7:0] exp_rdata;

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0;
    m_hold_addr = '0; m_hold_data = '0;
    exp_rvalid = '0;
  endtask

  // Applies the arbitration rules for one clock edge using current inputs.
  task automatic model_edge();
    int o, w;
    exp_rvalid = '0;
    if (m_owner < 0) begin
      w = rr_model(req_t, m_ptr);
      if (w >= 0) begin m_owner = w; m_last = w; end
    end else begin
      o = m_owner;
      m_hold_addr = addr_t[o];
      m_hold_data = wdata_t[o];
      if (req_t[o]) begin
        if (wren_t[o]) begin
          m_ram[addr_t[o]] = wdata_t[o];
          $display("%0t req%0d write [%02h]=%02h", $time, o, addr_t[o], wdata_t[o]);
        end else begin
          exp_rvalid[o] = 1'b1;
          exp_rdata = m_ram[addr_t[o]];
          $display("%0t req%0d read  [%02h] expect %02h", $time, o, addr_t[o], exp_rdata);
        end
      end else if (!lock_t[o]) begin
        m_ptr = (o + 1) % N;
        w = rr_model(req_t, m_ptr);
        m_owner = w;
        if (w >= 0) m_last = w;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction
  function automatic logic exp_wren_now();
    return (m_owner >= 0) && req_t[m_owner] && wren_t[m_owner];
  endfunction
  function automatic logic [7:0] exp_addr_now();
    return (m_owner >= 0) ? addr_t[m_owner] : m_hold_addr;
  endfunction
  function automatic logic [7:0] exp_data_now();
    return (m_owner >= 0) ? wdata_t[m_owner] : m_hold_data;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    req_t = '0; lock_t = '0; wren_t = '0;
    for (int i = 0; i < N; i++) begin addr_t[i] = '0; wdata_t[i] = '0; end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
    checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", bus.rvalid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    checks++; if (mem_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %02h want 00", mem_address); end
    checks++; if (mem_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", mem_data); end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int pulses = 0;
    req_t[2] = 1'b1; addr_t[2] = 8'h10; wren_t[2] = 1'b1; wdata_t[2] = 8'hA5;
    #1;
    pulses += int'(mem_wren);
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL single_wren_idle: got %b want 0", mem_wren); end
    tick();
    checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL single_gnt: got %b want 100", bus.gnt); end
    checks++; if (bus.owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d want 2", bus.owner); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    pulses += int'(mem_wren);
    checks++; if (mem_address !== 8'h10 || mem_data !== 8'hA5) begin errors++; $display("FAIL single_wr_bus: got %02h/%02h want 10/a5", mem_address, mem_data); end
    tick();
    wren_t[2] = 1'b0;
    #1;
    pulses += int'(mem_wren);
    tick();
    checks++; if (bus.rvalid !== 3'b100) begin errors++; $display("FAIL single_rvalid: got %b want 100", bus.rvalid); end
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL single_rdata: got %02h want a5", bus.rdata); end
    req_t[2] = 1'b0;
    #1;
    pulses += int'(mem_wren);
    tick();
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_wren_pulses: got %0d want 1", pulses); end
    checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL single_rvalid_once: got %b want 000", bus.rvalid); end
    checks++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_release: got gnt=%b busy=%b want 000/0", bus.gnt, bus.busy); end
  endtask

  task automatic test_contention();
    logic [N-1:0] done = '0;
    logic [N-1:0] accessing;
    int order[$];
    int prev = -1;
    int gaps = 0;
    int cyc;
    do_reset();
    for (int i = 0; i < N; i++) begin addr_t[i] = 8'h40 + 8'(i); wren_t[i] = 1'b0; end
    for (cyc = 0; cyc < 30 && done != 3'b111; cyc++) begin
      req_t = ~done;
      #1;
      accessing = bus.gnt & req_t;
      tick();
      done |= accessing;
      checks++; if (bus.gnt !== exp_gnt()) begin errors++; $display("FAIL cont_gnt: got %b want %b", bus.gnt, exp_gnt()); end
      if (bus.gnt != '0) begin
        if (bus.owner != 2'(prev)) begin prev = int'(bus.owner); order.push_back(prev); end
      end else if (done != 3'b111) gaps++;
    end
    checks++; if (done !== 3'b111) begin errors++; $display("FAIL cont_timeout: done=%b want 111", done); end
    checks++; if (order.size() != 3) begin errors++; $display("FAIL cont_order_len: got %0d want 3", order.size()); end
    else begin
      checks++; if (order[0] != 0 || order[1] != 1 || order[2] != 2) begin errors++; $display("FAIL cont_order: got %0d,%0d,%0d want 0,1,2", order[0], order[1], order[2]); end
    end
    checks++; if (gaps != 0) begin errors++; $display("FAIL cont_gaps: got %0d want 0", gaps); end
    req_t = '0;
    #1;
    tick();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL cont_idle: got %b want 000", bus.gnt); end
  endtask

  task automatic test_lock();
    int stolen = 0;
    req_t[1] = 1'b1; addr_t[1] = 8'h03; wren_t[1] = 1'b0;
    #1;
    tick();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL lock_gnt1: got %b want 010", bus.gnt); end
    req_t[0] = 1'b1; addr_t[0] = 8'h03; wren_t[0] = 1'b0;
    #1;
    tick();
    checks++; if (bus.rvalid !== 3'b010 || bus.rdata !== exp_rdata) begin errors++; $display("FAIL lock_rd03: got %b/%02h want 010/%02h", bus.rvalid, bus.rdata, exp_rdata); end
    addr_t[1] = 8'h07;
    #1;
    tick();
    checks++; if (bus.rvalid !== 3'b010 || bus.rdata !== exp_rdata) begin errors++; $display("FAIL lock_rd07: got %b/%02h want 010/%02h", bus.rvalid, bus.rdata, exp_rdata); end
    req_t[1] = 1'b0; lock_t[1] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      #1;
      checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL lock_gap_wren: got %b want 0", mem_wren); end
      tick();
      if (bus.gnt[0]) stolen++;
      checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL lock_gap_gnt: got %b want 010", bus.gnt); end
    end
    req_t[1] = 1'b1; wren_t[1] = 1'b1; addr_t[1] = 8'h03; wdata_t[1] = 8'h77;
    #1;
    tick();
    if (bus.gnt[0]) stolen++;
    addr_t[1] = 8'h07; wdata_t[1] = 8'h11;
    #1;
    tick();
    if (bus.gnt[0]) stolen++;
    checks++; if (stolen != 0) begin errors++; $display("FAIL lock_stolen: got %0d want 0", stolen); end
    req_t[1] = 1'b0; lock_t[1] = 1'b0; wren_t[1] = 1'b0;
    #1;
    tick();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL lock_handoff: got %b want 001", bus.gnt); end
    #1;
    tick();
    checks++; if (bus.rvalid !== 3'b001 || bus.rdata !== 8'h77) begin errors++; $display("FAIL lock_ram03: got %b/%02h want 001/77", bus.rvalid, bus.rdata); end
    addr_t[0] = 8'h07;
    #1;
    tick();
    checks++; if (bus.rdata !== 8'h11) begin errors++; $display("FAIL lock_ram07: got %02h want 11", bus.rdata); end
    req_t[0] = 1'b0;
    #1;
    tick();
  endtask

  task automatic test_nonowner();
    logic [7:0] old20;
    old20 = m_ram[8'h20];
    req_t[0] = 1'b1; wren_t[0] = 1'b1; addr_t[0] = 8'h41; wdata_t[0] = 8'h5A;
    #1;
    tick();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL nonown_gnt0: got %b want 001", bus.gnt); end
    req_t[2] = 1'b1; wren_t[2] = 1'b1; addr_t[2] = 8'h20; wdata_t[2] = 8'hFF;
    #1;
    checks++; if (mem_wren !== 1'b1 || mem_address !== 8'h41 || mem_data !== 8'h5A) begin errors++; $display("FAIL nonown_wr0: got %b %02h %02h want 1 41 5a", mem_wren, mem_address, mem_data); end
    tick();
    wren_t[0] = 1'b0;
    #1;
    checks++; if (mem_wren !== 1'b0 || mem_address !== 8'h41) begin errors++; $display("FAIL nonown_rd0: got %b %02h want 0 41", mem_wren, mem_address); end
    tick();
    req_t[0] = 1'b0;
    #1;
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL nonown_release_wren: got %b want 0", mem_wren); end
    tick();
    checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL nonown_gnt2: got %b want 100", bus.gnt); end
    wren_t[2] = 1'b0;
    #1;
    tick();
    checks++; if (bus.rvalid !== 3'b100 || bus.rdata !== old20) begin errors++; $display("FAIL nonown_old20: got %b/%02h want 100/%02h", bus.rvalid, bus.rdata, old20); end
    req_t[2] = 1'b0;
    #1;
    tick();
  endtask

  task automatic test_reset_mid();
    req_t[1] = 1'b1; wren_t[1] = 1'b1; addr_t[1] = 8'h50; wdata_t[1] = 8'h99;
    #1;
    tick();
    tick();
    req_t[1] = 1'b0;
    #1;
    tick();
    req_t[1] = 1'b1; addr_t[1] = 8'h51; wdata_t[1] = 8'h66;
    #1;
    tick();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL rstmid_gnt: got %b want 010", bus.gnt); end
    #1;
    checks++; if (mem_wren !== 1'b1) begin errors++; $display("FAIL rstmid_wren_pre: got %b want 1", mem_wren); end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rstmid_wren: got %b want 0", mem_wren); end
    checks++; if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin errors++; $display("FAIL rstmid_gnt_rvalid: got %b/%b want 000/000", bus.gnt, bus.rvalid); end
    set_idle();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    req_t[1] = 1'b1; req_t[2] = 1'b1;
    addr_t[1] = 8'h51; addr_t[2] = 8'h52;
    #1;
    tick();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL rstmid_ptr0: got %b want 010", bus.gnt); end
    #1;
    tick();
    checks++; if (bus.rdata !== m_ram[8'h51]) begin errors++; $display("FAIL rstmid_nowrite: got %02h want %02h", bus.rdata, m_ram[8'h51]); end
    req_t = '0;
    #1;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        req_t[i]   = ($urandom_range(0, 9) < 6);
        lock_t[i]  = ($urandom_range(0, 9) < 3);
        wren_t[i]  = $urandom_range(0, 1) == 1;
        addr_t[i]  = 8'($urandom_range(0, 15));
        wdata_t[i] = 8'($urandom);
      end
      #1;
      checks++; if (mem_wren !== exp_wren_now()) begin errors++; $display("FAIL rnd_wren c%0d: got %b want %b", cyc, mem_wren, exp_wren_now()); end
      checks++; if (mem_address !== exp_addr_now() || mem_data !== exp_data_now()) begin errors++; $display("FAIL rnd_bus c%0d: got %02h/%02h want %02h/%02h", cyc, mem_address, mem_data, exp_addr_now(), exp_data_now()); end
      tick();
      checks++; if (bus.gnt !== exp_gnt() || bus.busy !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_gnt c%0d: got %b/%b want %b", cyc, bus.gnt, bus.busy, exp_gnt()); end
      checks++; if (bus.owner !== 2'(m_last)) begin errors++; $display("FAIL rnd_owner c%0d: got %0d want %0d", cyc, bus.owner, m_last); end
      checks++; if (bus.rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, bus.rvalid, exp_rvalid); end
      if (exp_rvalid != '0) begin
        checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %02h want %02h", cyc, bus.rdata, exp_rdata); end
      end
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_ram[i] = init_val(i);
    model_reset();
    set_idle();
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_nonowner();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
